// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// responder FSM states and the byte-count helper.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic [3:0] nbytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension,
// and store merge of right-justified write data into an existing word.
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_o,
    output logic [63:0] merge_o
);

    logic [63:0] shifted;
    int unsigned off_w;
    int unsigned nb_w;

    assign shifted = word_i >> {offset_i, 3'b000};
    assign off_w   = 32'(offset_i);
    assign nb_w    = 32'(nbytes(size_i));

    always_comb begin
        load_o = '0;
        case (size_i)
            SZ_B:    load_o = {{56{signed_i & shifted[7]}},  shifted[7:0]};
            SZ_H:    load_o = {{48{signed_i & shifted[15]}}, shifted[15:0]};
            SZ_W:    load_o = {{32{signed_i & shifted[31]}}, shifted[31:0]};
            default: load_o = shifted;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i >= off_w && i < off_w + nb_w) begin
                merge_o[8*i +: 8] = wdata_i[8*(i - off_w) +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time over valid/ready,
// programmable wait states, sized/aligned access to a DEPTH x 64-bit array.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, signed_q, err_q;
    logic [63:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic [63:0] mem_q [DEPTH];

    logic        handshake, enter_resp, commit;
    logic        op_we, op_signed, op_err, misaligned, out_of_range;
    logic [63:0] op_addr, op_wdata, load_data, merged;
    logic [1:0]  op_size;
    logic [AW-1:0] idx;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign handshake  = req_valid & req_ready;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // With zero latency RESP is entered on the acceptance edge itself, so the
    // live request must be used before it has been captured.
    assign op_we     = (state_q == IDLE) ? req_we     : we_q;
    assign op_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    assign op_size   = (state_q == IDLE) ? req_size   : size_q;
    assign op_signed = (state_q == IDLE) ? req_signed : signed_q;
    assign op_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;

    always_comb begin
        misaligned = 1'b0;
        case (op_size)
            SZ_H:    misaligned = op_addr[0];
            SZ_W:    misaligned = |op_addr[1:0];
            SZ_D:    misaligned = |op_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = |(op_addr >> (AW + 3));
    assign op_err       = misaligned | out_of_range;
    assign idx          = op_addr[AW+2:3];
    assign commit       = enter_resp & op_we & ~op_err & ~reset;

    dmem_lane_align u_align (
        .word_i   (mem_q[idx]),
        .offset_i (op_addr[2:0]),
        .size_i   (op_size),
        .signed_i (op_signed),
        .wdata_i  (op_wdata),
        .load_o   (load_data),
        .merge_o  (merged)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (handshake) begin
                we_q     <= req_we;
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
            if (enter_resp) begin
                err_q   <= op_err;
                rdata_q <= (op_err || op_we) ? '0 : load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem_q[idx] <= merged;
    end

endmodule
